// File: rtl/ets_frame_reader_pkg.sv
// ets_pkg: shared state encoding and constants for the ETS frame reader.
// ETS_HDR_MAGIC is only consumed when ETS_FRAME_HEADER_EN is defined.
package ets_pkg;

  localparam int unsigned ETS_NUM_TAPS  = 616;
  localparam logic [15:0] ETS_HDR_MAGIC = 16'hE75A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    READ   = 2'd2,
    DRAIN  = 2'd3
  } ets_state_t;

endpackage

// File: rtl/ets_frame_reader_if.sv
// ets_frame_reader_if: triple-buffer read port plus the AXI4-Stream output.
// master = the frame reader, slave = buffer/packetiser side.
interface ets_frame_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              r_valid;
  logic [ADDR_W-1:0] raddr;
  logic              r_occur;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    input  r_valid, rdata, m_axis_tready,
    output raddr, r_occur, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output r_valid, rdata, m_axis_tready,
    input  raddr, r_occur, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/ets_frame_reader_fifo.sv
// ets_skid_fifo2: two-entry {data, last} FIFO; entry 0 is the head and
// drives the stream outputs directly, so the output is fully registered.
module ets_skid_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] data0, data1;
  logic              last0, last1;
  logic [1:0]        cnt;
  logic              pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = data0;
  assign out_last  = last0 & out_valid;
  assign count     = cnt;

  // Storage update: shift toward the head on pop, fill the first free slot on push.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            data0 <= push_data;
            last0 <= push_last;
            cnt   <= 2'd1;
          end else if (cnt == 2'd1) begin
            data1 <= push_data;
            last1 <= push_last;
            cnt   <= 2'd2;
          end
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ets_frame_reader.sv
// ets_frame_reader: reads one complete NUM_TAPS-word frame out of the ETS
// triple buffer and streams it as an AXI4-Stream packet with tlast.
// Optional macro ETS_FRAME_HEADER_EN prepends a {magic, frame_cnt} header beat.
//
// state  | meaning
// IDLE   | waiting for en & r_valid; raddr parked at 0
// HEADER | emitting the header beat (ETS_FRAME_HEADER_EN only)
// READ   | issuing reads 0..NUM_TAPS-1, one per cycle when the FIFO has room
// DRAIN  | all reads issued; waiting for the tlast beat to be accepted
module ets_frame_reader
  import ets_pkg::*;
#(
  parameter int NUM_TAPS = ETS_NUM_TAPS,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                en,
  ets_frame_reader_if.master  bus,
  output logic                frame_done,
  output logic [15:0]         frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

  ets_state_t        state;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_last;
  logic              pop;
  logic [2:0]        occupancy;
  logic              has_space;
  logic              issue;
  logic              read_issue;
  logic [DATA_W-1:0] push_data;

  // Words stored plus the one in flight, minus the one leaving this cycle,
  // must stay below 2 so a new issue can never overflow the FIFO.
  assign pop       = fifo_valid & bus.m_axis_tready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign has_space = (occupancy < 3'd2);

`ifdef ETS_FRAME_HEADER_EN
  logic inflight_hdr;

  assign issue     = ((state == READ) || (state == HEADER)) && has_space;
  assign push_data = inflight_hdr ? DATA_W'({ETS_HDR_MAGIC, frame_cnt}) : bus.rdata;

  // Header slot marker travels alongside the in-flight flag.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) inflight_hdr <= 1'b0;
    else          inflight_hdr <= issue && (state == HEADER);
  end
`else
  assign issue     = (state == READ) && has_space;
  assign push_data = bus.rdata;
`endif

  // r_occur depends on this cycle's pop, so it is decoded rather than registered.
  assign read_issue = issue && (state == READ);

  assign bus.raddr         = raddr_q;
  assign bus.r_occur       = read_issue;
  assign bus.m_axis_tdata  = fifo_data;
  assign bus.m_axis_tvalid = fifo_valid;
  assign bus.m_axis_tlast  = fifo_last;

  // Sequencer: state, read address, in-flight tracking and frame bookkeeping.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      raddr_q       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      inflight      <= issue;
      inflight_last <= read_issue && (raddr_q == LAST_ADDR);
      frame_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (en && bus.r_valid) begin
            raddr_q <= '0;
`ifdef ETS_FRAME_HEADER_EN
            state   <= HEADER;
`else
            state   <= READ;
`endif
          end
        end
`ifdef ETS_FRAME_HEADER_EN
        HEADER: begin
          if (issue) state <= READ;
        end
`endif
        READ: begin
          if (issue) begin
            if (raddr_q == LAST_ADDR) state <= DRAIN;
            else                      raddr_q <= raddr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && fifo_last) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            raddr_q    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ets_skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (push_data),
    .push_last (inflight_last),
    .out_valid (fifo_valid),
    .out_ready (bus.m_axis_tready),
    .out_data  (fifo_data),
    .out_last  (fifo_last),
    .count     (fifo_count)
  );

endmodule
